bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter.sv | 175 +++++++++++++++++
 tb/tb_bus_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - round-robin multi-master arbiter driving a five-phase bus transaction
module bus_arbiter #(
    parameter int NUM_M  = 4,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_M-1:0]         m_req,
    input  logic [NUM_M-1:0]         m_we,
    input  logic [NUM_M*ADDR_W-1:0]  m_addr,
    input  logic [NUM_M*DATA_W-1:0]  m_wdata,
    output logic [NUM_M-1:0]         m_gnt,
    output logic [NUM_M-1:0]         m_done,
    output logic [DATA_W-1:0]        m_rdata,
    output logic                     bus_ale_en,
    output logic                     bus_read_en,
    output logic                     bus_write_en,
    output logic [ADDR_W-1:0]        bus_addr,
    output logic [DATA_W-1:0]        bus_wdata,
    input  logic [DATA_W-1:0]        bus_rdata,
    output logic                     busy
);

    localparam int IDX_W = (NUM_M > 1) ? $clog2(NUM_M) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ALE,
        S_XFER,
        S_WAIT,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]    win_q, win_d;
    logic                we_q, we_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [NUM_M-1:0]    gnt_q, gnt_d;
    logic [NUM_M-1:0]    done_q, done_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                ale_q, ale_d;
    logic                rd_q, rd_d;
    logic                wr_q, wr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   bwdata_q, bwdata_d;
    logic                busy_q, busy_d;

    logic                found;
    logic [IDX_W-1:0]    winner;

    // First requester at or above rr_ptr, wrapping around.
    always_comb begin
        int idx;
        idx    = 0;
        found  = 1'b0;
        winner = '0;
        for (int k = 0; k < NUM_M; k++) begin
            idx = (int'(rr_ptr_q) + k) % NUM_M;
            if (!found && m_req[idx]) begin
                found  = 1'b1;
                winner = IDX_W'(idx);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        win_d    = win_q;
        we_d     = we_q;
        wdata_d  = wdata_q;
        gnt_d    = gnt_q;
        done_d   = done_q;
        rdata_d  = rdata_q;
        ale_d    = ale_q;
        rd_d     = rd_q;
        wr_d     = wr_q;
        addr_d   = addr_q;
        bwdata_d = bwdata_q;
        busy_d   = busy_q;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    state_d = S_ALE;
                    win_d   = winner;
                    we_d    = m_we[winner];
                    addr_d  = m_addr[int'(winner)*ADDR_W +: ADDR_W];
                    wdata_d = m_wdata[int'(winner)*DATA_W +: DATA_W];
                    gnt_d   = '0;
                    gnt_d[winner] = 1'b1;
                    ale_d   = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            S_ALE: begin
                state_d  = S_XFER;
                ale_d    = 1'b0;
                rd_d     = ~we_q;
                wr_d     = we_q;
                bwdata_d = we_q ? wdata_q : '0;
            end
            S_XFER: begin
                state_d = S_WAIT;
                rd_d    = 1'b0;
                wr_d    = 1'b0;
            end
            S_WAIT: begin
                state_d = S_DONE;
                done_d  = gnt_q;
                if (!we_q) begin
                    rdata_d = bus_rdata;
                end
            end
            S_DONE: begin
                state_d  = S_IDLE;
                done_d   = '0;
                gnt_d    = '0;
                addr_d   = '0;
                bwdata_d = '0;
                busy_d   = 1'b0;
                rr_ptr_d = (win_q == IDX_W'(NUM_M - 1)) ? '0 : win_q + IDX_W'(1);
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= '0;
            win_q    <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            gnt_q    <= '0;
            done_q   <= '0;
            rdata_q  <= '0;
            ale_q    <= 1'b0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            bwdata_q <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            win_q    <= win_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            rdata_q  <= rdata_d;
            ale_q    <= ale_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            addr_q   <= addr_d;
            bwdata_q <= bwdata_d;
            busy_q   <= busy_d;
        end
    end

    assign m_gnt        = gnt_q;
    assign m_done       = done_q;
    assign m_rdata      = rdata_q;
    assign bus_ale_en   = ale_q;
    assign bus_read_en  = rd_q;
    assign bus_write_en = wr_q;
    assign bus_addr     = addr_q;
    assign bus_wdata    = bwdata_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - table-driven and sequence checks for bus_arbiter
module tb_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  m_req;
    logic [3:0]  m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_gnt;
    logic [3:0]  m_done;
    logic [7:0]  m_rdata;
    logic        bus_ale_en;
    logic        bus_read_en;
    logic        bus_write_en;
    logic [7:0]  bus_addr;
    logic [7:0]  bus_wdata;
    logic [7:0]  bus_rdata;
    logic        busy;

    int n_chk  = 0;
    int n_fail = 0;

    bus_arbiter #(.NUM_M(4), .ADDR_W(8), .DATA_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .m_req        (m_req),
        .m_we         (m_we),
        .m_addr       (m_addr),
        .m_wdata      (m_wdata),
        .m_gnt        (m_gnt),
        .m_done       (m_done),
        .m_rdata      (m_rdata),
        .bus_ale_en   (bus_ale_en),
        .bus_read_en  (bus_read_en),
        .bus_write_en (bus_write_en),
        .bus_addr     (bus_addr),
        .bus_wdata    (bus_wdata),
        .bus_rdata    (bus_rdata),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] rdata;
        int         win;
        logic [7:0] exp_rdata;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic set_master(input int i, input logic we, input logic [7:0] a, input logic [7:0] d);
        m_we[i]          = we;
        m_addr[i*8 +: 8] = a;
        m_wdata[i*8 +: 8] = d;
    endtask

    function automatic logic [63:0] all_out();
        return {m_gnt, m_done, m_rdata, bus_ale_en, bus_read_en, bus_write_en,
                bus_addr, bus_wdata, busy};
    endfunction

    task automatic run_vec(input vec_t v);
        logic [3:0] oh;
        oh = 4'b0001 << v.win;
        for (int i = 0; i < 4; i++) begin
            if (i == v.win) set_master(i, v.we, v.addr, v.wdata);
            else            set_master(i, ~v.we, ~v.addr, ~v.wdata);
        end
        m_req = v.req;
        tick();
        chk("ale_ctl", {m_gnt, m_done, bus_ale_en, bus_read_en, bus_write_en, busy},
            {oh, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1});
        chk("ale_addr", bus_addr, v.addr);
        m_req   = 4'b0000;
        m_we    = ~m_we;
        m_addr  = ~m_addr;
        m_wdata = ~m_wdata;
        tick();
        chk("xfer_ctl", {bus_ale_en, bus_read_en, bus_write_en}, {1'b0, ~v.we, v.we});
        chk("xfer_bus", {bus_addr, bus_wdata}, {v.addr, (v.we ? v.wdata : 8'h00)});
        tick();
        chk("wait_ctl", {bus_ale_en, bus_read_en, bus_write_en, m_done}, 7'b0);
        chk("wait_bus", {bus_addr, bus_wdata}, {v.addr, (v.we ? v.wdata : 8'h00)});
        bus_rdata = v.rdata;
        tick();
        chk("done_pulse", {m_done, m_gnt}, {oh, oh});
        chk("done_rdata", m_rdata, v.exp_rdata);
        bus_rdata = 8'h00;
        tick();
        chk("idle_after", {m_gnt, m_done, bus_addr, bus_wdata, busy, bus_read_en, bus_write_en},
            27'b0);
        chk("rdata_hold", m_rdata, v.exp_rdata);
    endtask

    initial begin
        int         gcyc[6];
        int         gwho[6];
        int         ng;
        logic [3:0] prev_gnt;
        logic [3:0] prev_done;
        int         order_exp[6];

        vecs[0] = '{4'b0010, 1'b1, 8'h3C, 8'hA5, 8'hEE, 1, 8'h00};
        vecs[1] = '{4'b0100, 1'b0, 8'h3C, 8'h00, 8'hA5, 2, 8'hA5};
        vecs[2] = '{4'b1011, 1'b1, 8'h10, 8'h5A, 8'h33, 3, 8'hA5};
        vecs[3] = '{4'b0110, 1'b0, 8'h20, 8'h00, 8'h77, 1, 8'h77};
        vecs[4] = '{4'b0011, 1'b0, 8'h44, 8'h00, 8'hC3, 0, 8'hC3};
        vecs[5] = '{4'b1001, 1'b1, 8'h81, 8'h99, 8'h11, 3, 8'hC3};
        order_exp = '{0, 1, 2, 3, 0, 1};

        rst = 1'b1; m_req = '0; m_we = '0; m_addr = '0; m_wdata = '0; bus_rdata = '0;
        do_reset();
        chk("reset_outputs", all_out(), 64'b0);

        for (int c = 0; c < 3; c++) begin
            tick();
            chk("idle_no_req", {busy, m_gnt, bus_ale_en, bus_read_en, bus_write_en}, 8'b0);
        end

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // All masters requesting continuously from reset: strict rotation, 5-cycle spacing.
        m_req = 4'b1111;
        for (int i = 0; i < 4; i++) set_master(i, 1'b1, 8'(i), 8'(i + 8'h10));
        do_reset();
        ng = 0; prev_gnt = '0; prev_done = '0;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (m_gnt != 4'b0 && prev_gnt == 4'b0 && ng < 6) begin
                gcyc[ng] = c;
                gwho[ng] = -1;
                for (int b = 0; b < 4; b++) if (m_gnt[b]) gwho[ng] = b;
                ng++;
            end
            if (m_done != 4'b0) chk("rr_done_to_gnt", m_done, m_gnt);
            chk("rr_done_single", m_done & prev_done, 4'b0);
            prev_gnt  = m_gnt;
            prev_done = m_done;
        end
        chk("rr_grant_count", ng, 6);
        for (int i = 0; i < 6; i++) begin
            if (i < ng) begin
                chk("rr_order", gwho[i], order_exp[i]);
                if (i > 0) chk("rr_spacing", gcyc[i] - gcyc[i-1], 5);
            end
        end
        m_req = '0;

        // Master 0 withdraws and moves its address right after grant.
        do_reset();
        set_master(0, 1'b0, 8'h42, 8'h00);
        m_req = 4'b0001;
        tick();
        chk("chg_gnt", {m_gnt, bus_addr}, {4'b0001, 8'h42});
        m_req = 4'b0000;
        m_addr[7:0] = 8'hFF;
        m_we[0] = 1'b1;
        tick();
        chk("chg_xfer", {bus_addr, bus_read_en, bus_write_en}, {8'h42, 1'b1, 1'b0});
        bus_rdata = 8'h6D;
        tick();
        chk("chg_wait", bus_addr, 8'h42);
        tick();
        chk("chg_done", {m_done, m_rdata}, {4'b0001, 8'h6D});
        bus_rdata = 8'h00;
        tick();

        // Reset during S_XFER aborts the transfer; rotation restarts at master 0.
        do_reset();
        set_master(2, 1'b1, 8'h55, 8'hAA);
        m_req = 4'b0100;
        tick();
        m_req = 4'b0000;
        tick();
        chk("abort_xfer", {m_gnt, bus_write_en, bus_wdata}, {4'b0100, 1'b1, 8'hAA});
        rst = 1'b1;
        tick();
        chk("abort_outputs", all_out(), 64'b0);
        rst = 1'b0;
        m_req = 4'b1111;
        tick();
        chk("abort_regrant", {m_gnt, m_done}, {4'b0001, 4'b0000});
        m_req = 4'b0000;
        tick();
        chk("abort_no_done", m_done, 4'b0);
        tick();
        tick();
        chk("abort_new_done", m_done, 4'b0001);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
